csr_exec_unit: RTL and testbench

- Execution stage directly downstream of the CSR issue queue. It consumes one issued CSR instruction (operand value plus bundle) and performs the CSRRW/CSRRS/CSRRC read-modify-write, including the immediate forms.
- It owns a small machine-mode CSR file, including free-running mcycle/minstret counters.
- It produces one writeback (rd value or illegal-instruction flag) through a valid/ready output register that can be killed by redirect.

---
 rtl/csr_exec_unit_pkg.sv | 59 +++++
 rtl/csr_exec_unit_regfile.sv | 58 +++++
 rtl/csr_exec_unit.sv | 100 ++++++++++
 tb/tb_csr_exec_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/csr_exec_unit_pkg.sv
// Shared types for the CSR execution stage: CSR addresses, funct3 encoding,
// the output-register payload and ROB age comparison.
package csr_exec_unit_pkg;
  localparam int XLEN       = 32;
  localparam int PREG_WIDTH = 7;
  localparam int ROB_WIDTH  = 6;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0, OP_RW  = 3'd1, OP_RS  = 3'd2, OP_RC  = 3'd3,
    OP_RSV  = 3'd4, OP_RWI = 3'd5, OP_RSI = 3'd6, OP_RCI = 3'd7
  } CsrOp;

  typedef logic [ROB_WIDTH:0] rob_idx_t;

  typedef struct packed {
    logic [PREG_WIDTH-1:0] rd;
    logic [XLEN-1:0]       data;
    rob_idx_t              robIdx;
    logic                  exc;
    logic                  wen;
    logic [11:0]           waddr;
    logic [XLEN-1:0]       wdata;
  } CsrExecOut;

  // MSB is the wrap direction bit; differing directions invert the index order.
  function automatic logic older(input rob_idx_t a, input rob_idx_t b);
    if (a[ROB_WIDTH] == b[ROB_WIDTH]) return a[ROB_WIDTH-1:0] < b[ROB_WIDTH-1:0];
    return a[ROB_WIDTH-1:0] > b[ROB_WIDTH-1:0];
  endfunction

  // {hit, slot} for the plain read/write CSRs held in the flat file.
  function automatic logic [3:0] plain_slot(input logic [11:0] a);
    case (a)
      CSR_MSTATUS:  return 4'h8;
      CSR_MIE:      return 4'h9;
      CSR_MTVEC:    return 4'hA;
      CSR_MSCRATCH: return 4'hB;
      CSR_MEPC:     return 4'hC;
      CSR_MCAUSE:   return 4'hD;
      CSR_MTVAL:    return 4'hE;
      CSR_MIP:      return 4'hF;
      default:      return 4'h0;
    endcase
  endfunction
endpackage

// File: rtl/csr_exec_unit_regfile.sv
// Machine-mode CSR storage with free-running counters; reads see the write
// being retired in the same cycle.
module csr_regfile
  import csr_exec_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     raddr,
  output logic [XLEN-1:0] rdata,
  output logic            illegal_addr,
  input  logic            wen,
  input  logic [11:0]     waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [1:0]      commit_num
);
  logic [7:0][XLEN-1:0] file_q, file_d;
  logic [XLEN-1:0]      mcycle_q, mcycle_d, minstret_q, minstret_d;
  logic [3:0]           wslot, rslot;
  logic                 wr_mcycle, wr_minstret;

  assign wslot       = plain_slot(waddr);
  assign rslot       = plain_slot(raddr);
  assign wr_mcycle   = wen && (waddr == CSR_MCYCLE);
  assign wr_minstret = wen && (waddr == CSR_MINSTRET);

  always_comb begin
    file_d = file_q;
    if (wen && wslot[3]) file_d[wslot[2:0]] = wdata;
    mcycle_d   = wr_mcycle   ? wdata : mcycle_q + XLEN'(1);
    minstret_d = wr_minstret ? wdata : minstret_q + XLEN'(commit_num);
  end

  always_comb begin
    rdata        = '0;
    illegal_addr = 1'b0;
    if (rslot[3]) rdata = file_d[rslot[2:0]];
    else begin
      case (raddr)
        CSR_MCYCLE,   CSR_CYCLE:   rdata = wr_mcycle   ? wdata : mcycle_q;
        CSR_MINSTRET, CSR_INSTRET: rdata = wr_minstret ? wdata : minstret_q;
        CSR_MHARTID:               rdata = '0;
        default:                   illegal_addr = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      file_q     <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      file_q     <= file_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
endmodule

// File: rtl/csr_exec_unit.sv
// CSR execute stage: read-modify-write in the issue cycle, result held in a
// killable valid/ready output register; the CSR write retires on hand-off.
module csr_exec_unit
  import csr_exec_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_en,
  output logic                  issue_ready,
  input  logic [XLEN-1:0]       issue_rdata,
  input  logic [2:0]            issue_op,
  input  logic [4:0]            issue_imm,
  input  logic [11:0]           issue_csrid,
  input  logic [PREG_WIDTH-1:0] issue_rd,
  input  logic [ROB_WIDTH:0]    issue_robIdx,
  input  logic                  redirect,
  input  logic [ROB_WIDTH:0]    redirect_idx,
  input  logic [1:0]            commit_num,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [PREG_WIDTH-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_data,
  output logic [ROB_WIDTH:0]    wb_robIdx,
  output logic                  wb_exc
);
  CsrExecOut       out_q, out_d;
  logic            out_valid_q, out_valid_d;
  logic            kill, fire_in, fire_out;
  logic [XLEN-1:0] old_val, src, new_val;
  logic            illegal_addr, illegal_op, wr_intent, illegal;
  CsrOp            op;

  assign op          = CsrOp'(issue_op);
  assign kill        = redirect && out_valid_q && !older(out_q.robIdx, redirect_idx);
  assign issue_ready = !out_valid_q || wb_ready;
  assign fire_in     = issue_en && issue_ready && !redirect;
  assign fire_out    = out_valid_q && wb_ready && !kill && !out_q.exc;

  csr_regfile u_regfile (
    .clk          (clk),
    .rst          (rst),
    .raddr        (issue_csrid),
    .rdata        (old_val),
    .illegal_addr (illegal_addr),
    .wen          (fire_out && out_q.wen),
    .waddr        (out_q.waddr),
    .wdata        (out_q.wdata),
    .commit_num   (commit_num)
  );

  always_comb begin
    src        = issue_op[2] ? XLEN'(issue_imm) : issue_rdata;
    // Set/clear forms only write when rs1/zimm field is non-zero.
    wr_intent  = (issue_op[1:0] == 2'd1) || (issue_imm != '0);
    illegal_op = 1'b0;
    case (op)
      OP_RW, OP_RWI: new_val = src;
      OP_RS, OP_RSI: new_val = old_val | src;
      OP_RC, OP_RCI: new_val = old_val & ~src;
      default: begin
        new_val    = '0;
        illegal_op = 1'b1;
      end
    endcase
    illegal = illegal_op || illegal_addr || (wr_intent && (issue_csrid[11:10] == 2'b11));
  end

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (fire_in) begin
      out_valid_d  = 1'b1;
      out_d.rd     = issue_rd;
      out_d.robIdx = issue_robIdx;
      out_d.exc    = illegal;
      out_d.data   = illegal ? '0 : old_val;
      out_d.wen    = wr_intent && !illegal;
      out_d.waddr  = issue_csrid;
      out_d.wdata  = new_val;
    end else if (out_valid_q && (wb_ready || kill)) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign wb_valid  = out_valid_q && !kill;
  assign wb_rd     = out_q.rd;
  assign wb_data   = out_q.data;
  assign wb_robIdx = out_q.robIdx;
  assign wb_exc    = out_q.exc;
endmodule

// File: tb/tb_csr_exec_unit.sv
// Directed and random checks of csr_exec_unit against a CSR-map reference model.
module tb_csr_exec_unit;
  logic        clk = 1'b0, rst = 1'b0;
  logic        issue_en = 0, issue_ready, redirect = 0, wb_valid, wb_ready = 1, wb_exc;
  logic [31:0] issue_rdata = 0, wb_data;
  logic [2:0]  issue_op = 0;
  logic [4:0]  issue_imm = 0;
  logic [11:0] issue_csrid = 0;
  logic [6:0]  issue_rd = 0, issue_robIdx = 0, redirect_idx = 0, wb_rd, wb_robIdx;
  logic [1:0]  commit_num = 0;

  int checks = 0, errors = 0;

  // reference model state
  logic [31:0] mreg [logic [11:0]];
  logic [31:0] mc, mi;
  bit          pv, p_exc, p_wen;
  logic [6:0]  p_rd, p_rob;
  logic [31:0] p_data, p_wdata;
  logic [11:0] p_addr;

  always #5 clk = ~clk;

  csr_exec_unit dut (
    .clk(clk), .rst(rst), .issue_en(issue_en), .issue_ready(issue_ready),
    .issue_rdata(issue_rdata), .issue_op(issue_op), .issue_imm(issue_imm),
    .issue_csrid(issue_csrid), .issue_rd(issue_rd), .issue_robIdx(issue_robIdx),
    .redirect(redirect), .redirect_idx(redirect_idx), .commit_num(commit_num),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_robIdx(wb_robIdx), .wb_exc(wb_exc)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ROB index is a 7-bit wrapping counter over a 64-entry ROB: a is older if b is 1..63 ahead.
  function automatic bit older_m(input logic [6:0] a, input logic [6:0] b);
    logic [6:0] d;
    d = b - a;
    return d >= 1 && d <= 63;
  endfunction

  function automatic logic [31:0] mread(input logic [11:0] a);
    if (a == 12'hB00 || a == 12'hC00) return mc;
    if (a == 12'hB02 || a == 12'hC02) return mi;
    if (mreg.exists(a)) return mreg[a];
    return 32'd0;
  endfunction

  function automatic bit impl(input logic [11:0] a);
    return mreg.exists(a) || (a inside {12'hB00, 12'hB02, 12'hC00, 12'hC02, 12'hF14});
  endfunction

  function automatic bit kill_now();
    return pv && redirect && !older_m(p_rob, redirect_idx);
  endfunction

  task automatic model_reset();
    logic [11:0] plain [8];
    plain = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344};
    mreg.delete();
    foreach (plain[i]) mreg[plain[i]] = 32'd0;
    mc = 0; mi = 0; pv = 0;
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_step();
    bit kill, fo, fi, mcw, miw, wi, ill;
    logic [31:0] src, oldv, newv;
    kill = kill_now();
    fo = pv && wb_ready && !kill && !p_exc;
    fi = issue_en && (!pv || wb_ready) && !redirect;
    mcw = 0; miw = 0;
    if (fo && p_wen) begin
      if (p_addr == 12'hB00) begin mc = p_wdata; mcw = 1; end
      else if (p_addr == 12'hB02) begin mi = p_wdata; miw = 1; end
      else mreg[p_addr] = p_wdata;
    end
    if (fi) begin
      src  = (issue_op >= 3'd5) ? {27'd0, issue_imm} : issue_rdata;
      wi   = (issue_op == 3'd1 || issue_op == 3'd5) || issue_imm != 0;
      ill  = (issue_op == 3'd0 || issue_op == 3'd4) || !impl(issue_csrid) ||
             (wi && issue_csrid >= 12'hC00);
      oldv = mread(issue_csrid);
      case (issue_op % 4)
        1:       newv = src;
        2:       newv = oldv | src;
        default: newv = oldv & ~src;
      endcase
      pv = 1; p_rd = issue_rd; p_rob = issue_robIdx; p_exc = ill;
      p_data = ill ? 32'd0 : oldv; p_wen = wi && !ill; p_addr = issue_csrid; p_wdata = newv;
    end else if (pv && (wb_ready || kill)) pv = 0;
    if (!mcw) mc = mc + 1;
    if (!miw) mi = mi + 32'(commit_num);
  endtask

  // Called just after a negedge with inputs set: check, model the edge, advance.
  task automatic step();
    #1;
    chk("wb_valid", wb_valid, pv && !kill_now());
    chk("issue_ready", issue_ready, !pv || wb_ready);
    if (pv) begin
      chk("wb_data", wb_data, p_data);
      chk("wb_exc", wb_exc, p_exc);
      chk("wb_rd", wb_rd, p_rd);
      chk("wb_robIdx", wb_robIdx, p_rob);
    end
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic iss(input logic [2:0] op, input logic [11:0] a, input logic [31:0] d,
                     input logic [4:0] imm, input logic [6:0] rob);
    issue_en = 1; issue_op = op; issue_csrid = a; issue_rdata = d; issue_imm = imm;
    issue_robIdx = rob; issue_rd = 7'($urandom);
    step();
    issue_en = 0;
  endtask

  task automatic kill_case(input logic [6:0] ridx, input logic [31:0] val, input bit survives);
    iss(3'd1, 12'h341, val, 5'd3, 7'd5);
    redirect = 1; redirect_idx = ridx;
    #1 chk("redirect_wb_valid", wb_valid, survives);
    step();
    redirect = 0;
  endtask

  initial begin
    logic [11:0] addrs [16];
    addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
              12'hB00, 12'hB02, 12'hC00, 12'hC02, 12'hF14, 12'h7C0, 12'h301, 12'hC01};
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_exc", wb_exc, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_robIdx", wb_robIdx, 0);
    @(negedge clk);
    rst = 1;
    step();

    iss(3'd2, 12'h340, 32'h1234, 5'd0, 7'd1);
    chk("mscratch_init", wb_data, 0);
    iss(3'd1, 12'h340, 32'hDEADBEEF, 5'd5, 7'd2);
    iss(3'd2, 12'h340, 32'h0000F000, 5'd6, 7'd3);
    chk("rs_old", wb_data, 32'hDEADBEEF);
    iss(3'd2, 12'h340, 32'h0, 5'd0, 7'd4);
    chk("rs_result", wb_data, 32'hDEADFEEF);
    iss(3'd2, 12'hC00, 32'h0, 5'd0, 7'd5);
    chk("cycle_ro_read_exc", wb_exc, 0);
    iss(3'd1, 12'hF14, 32'h55, 5'd1, 7'd6);
    chk("mhartid_write_exc", wb_exc, 1);
    chk("exc_data_zero", wb_data, 0);
    iss(3'd2, 12'hF14, 32'h0, 5'd0, 7'd7);
    chk("mhartid_zero", wb_data, 0);
    iss(3'd1, 12'h7C0, 32'h1, 5'd1, 7'd8);
    chk("unimpl_exc", wb_exc, 1);
    iss(3'd4, 12'h340, 32'h1, 5'd1, 7'd9);
    chk("op4_exc", wb_exc, 1);

    // stall with a pending mtvec write; blocked issue attempts are ignored
    iss(3'd1, 12'h305, 32'h12345678, 5'd1, 7'd10);
    wb_ready = 0; issue_en = 1; issue_op = 3'd1; issue_csrid = 12'h305; issue_rdata = 32'hBAD;
    repeat (3) step();
    wb_ready = 1;
    iss(3'd2, 12'h305, 32'h0, 5'd0, 7'd11);
    chk("mtvec_bypass", wb_data, 32'h12345678);

    kill_case(7'h05, 32'hAAAA, 0);
    iss(3'd2, 12'h341, 32'h0, 5'd0, 7'd12);
    chk("killed_no_write", wb_data, 0);
    kill_case(7'h06, 32'h1111, 1);
    iss(3'd2, 12'h341, 32'h0, 5'd0, 7'd13);
    chk("survive_same_dir", wb_data, 32'h1111);
    kill_case(7'h42, 32'h2222, 1);
    iss(3'd2, 12'h341, 32'h0, 5'd0, 7'd14);
    chk("survive_wrap", wb_data, 32'h2222);

    iss(3'd1, 12'hB00, 32'd100, 5'd1, 7'd15);
    commit_num = 2;
    iss(3'd2, 12'hB00, 32'h0, 5'd0, 7'd16);
    chk("mcycle_bypass", wb_data, 100);
    iss(3'd2, 12'hB00, 32'h0, 5'd0, 7'd17);
    chk("mcycle_written", wb_data, 100);
    iss(3'd2, 12'hB00, 32'h0, 5'd0, 7'd18);
    chk("mcycle_incr", wb_data, 101);
    iss(3'd2, 12'hB02, 32'h0, 5'd0, 7'd19);
    commit_num = 0;

    for (int n = 0; n < 400; n++) begin
      issue_en     = ($urandom_range(0, 9) < 7);
      issue_op     = 3'($urandom);
      issue_csrid  = addrs[$urandom_range(0, 15)];
      issue_rdata  = $urandom;
      issue_imm    = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom);
      issue_rd     = 7'($urandom);
      issue_robIdx = 7'($urandom);
      wb_ready     = ($urandom_range(0, 3) != 0);
      redirect     = ($urandom_range(0, 9) == 0);
      redirect_idx = 7'($urandom);
      commit_num   = 2'($urandom);
      step();
    end
    issue_en = 0; redirect = 0; wb_ready = 1; commit_num = 0;

    // reset with a write pending: write discarded, counters cleared
    iss(3'd1, 12'h340, 32'hCAFE, 5'd1, 7'd20);
    wb_ready = 0;
    rst = 0;
    #1 chk("midrst_wb_valid", wb_valid, 0);
    model_reset();
    @(negedge clk);
    rst = 1; wb_ready = 1;
    iss(3'd2, 12'h340, 32'h0, 5'd0, 7'd21);
    chk("midrst_no_write", wb_data, 0);
    iss(3'd2, 12'hB00, 32'h0, 5'd0, 7'd22);
    iss(3'd2, 12'hB02, 32'h0, 5'd0, 7'd23);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
